mips_mc_ctrl_ext: RTL and testbench
===================================

Name: mips_mc_ctrl_ext

Overview:
Parametrised multicycle MIPS control FSM, the successor to the current control_unit plus misc_logic pair. It extends the instruction set with bne, addi, andi, ori, j, sll and srl. It adds a mem_ready wait handshake for variable-latency memory and absorbs the PCEn logic. It also keeps a retired-instruction counter, and sits between the instruction register and the existing datapath muxes and ALU.

Parameters:
BIT_SEL, 3, ALUControl width is BIT_SEL+1
CNT_WIDTH, 16, width of the retired-instruction counter
STATE_W, 4, state register width (13 states used)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
Op  input  6  instruction[31:26]
Funct  input  6  instruction[5:0]
Zero  input  1  ALU zero flag
mem_ready  input  1  memory access completes this cycle
IorD  output  1  0=PC, 1=ALUOut address
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
RegWrite  output  1  register file write
RegDst  output  1  0=rt, 1=rd
MemtoReg  output  1  0=ALUOut, 1=memory data
ALUSrcA  output  2  00=PC, 01=A, 10=shamt
ALUSrcB  output  2  00=B, 01=4, 10=Imm, 11=Imm<<2
ImmZext  output  1  1=zero-extend imm16 (andi/ori)
PCSrc  output  2  00=ALUResult, 01=ALUOut, 10={PC[31:28],instr[25:0],2'b00}
ALUControl  output  BIT_SEL+1  AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLL 1000, SRL 1001, NOR 1100
PCEn  output  1  PC load enable
illegal_op  output  1  one-cycle pulse on an undecodable instruction
retired  output  CNT_WIDTH  retired-instruction count
DFT_state  output  STATE_W  state visibility (see Optional Feature)

Behaviour:
- Reset: while rst=0, state is FETCH, retired=0, illegal_op=0. IRWrite, PCEn, MemWrite and RegWrite are forced to 0. All other outputs take their FETCH values.
- Outputs are Moore, decoded from state. The only exceptions are mem_ready gating and Zero, which act combinationally on PCEn.
- Any output not listed for a state below is 0.
- FETCH: IorD=0, ALUSrcA=00, ALUSrcB=01, ADD, PCSrc=00. IRWrite=PCEn=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: ALUSrcA=00, ALUSrcB=11, ADD (branch target to ALUOut). Next state by opcode:
  - 100011/101011 -> MEMADR
  - 000000 -> RTYPE_EX, or SHIFT_EX if Funct is 000000/000010
  - 000100/000101 -> BRANCH
  - 001000/001100/001101 -> IMM_EX
  - 000010 -> JUMP
  - undefined Op, or R-type Funct outside {100000,100010,100100,100101,100111,101010,000000,000010} -> FETCH with illegal_op=1 for this cycle
- DECODE latches an internal op class so later states do not depend on the instruction register.
- MEMADR: ALUSrcA=01, ALUSrcB=10, ADD. Next MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next FETCH.
- MEMWR: IorD=1, MemWrite=mem_ready. Wait for mem_ready, then go to FETCH.
- RTYPE_EX: ALUSrcA=01, ALUSrcB=00, ALUControl from Funct (add, sub, and, or, nor, slt). Next ALU_WB.
- SHIFT_EX: ALUSrcA=10, ALUSrcB=00, SLL or SRL. Next ALU_WB.
- ALU_WB: RegDst=1, MemtoReg=0, RegWrite=1. Next FETCH.
- IMM_EX: ALUSrcA=01, ALUSrcB=10.
  - addi: ADD, ImmZext=0
  - andi: AND, ImmZext=1
  - ori: OR, ImmZext=1
  - Next IMM_WB.
- IMM_WB: RegDst=0, MemtoReg=0, RegWrite=1. Next FETCH.
- BRANCH: ALUSrcA=01, ALUSrcB=00, SUB, PCSrc=01. PCEn=Zero for beq, ~Zero for bne. Next FETCH.
- JUMP: PCSrc=10, PCEn=1. Next FETCH.
- retired increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALU_WB, IMM_WB, BRANCH or JUMP. It does not increment on the illegal path. It wraps to 0 after all ones.
- Latency with mem_ready held at 1: lw 5 cycles; sw, R-type, shift and imm 4 cycles; branch and j 3 cycles.
- Reset asserted mid-instruction: immediate return to FETCH. No partial MemWrite or RegWrite is issued after rst falls.

Optional Feature:
MIPS_MC_CTRL_DFT_EN defined: DFT_state drives the state register encoding (FETCH=0, DECODE=1, then in listed order up to JUMP=12).
Not defined: DFT_state is tied to 0 and no extra logic is added.

Test Plan:
- Release rst with mem_ready=1, Op=100011 -> states 0,1,2,3,4,0; RegWrite=1 with MemtoReg=1 in cycle 5; retired 0 -> 1.
- FETCH with mem_ready=0 for 3 cycles, then 1 -> IRWrite and PCEn stay 0 for 3 cycles, pulse 1 in cycle 4, then DECODE.
- Op=000101 with Zero=0 -> PCEn=1, PCSrc=01 in BRANCH; Op=000101 with Zero=1 -> PCEn=0.
- Op=000000, Funct=000010 -> SHIFT_EX with ALUSrcA=10, ALUControl=1001; then ALU_WB with RegDst=1.
- Op=111111 -> illegal_op=1 for one cycle in DECODE, next state FETCH, retired unchanged.
- Op=101011 with mem_ready=0 in MEMWR, rst driven low -> MemWrite=0 and state=FETCH immediately; retired=0.

Source files
------------

// File: rtl/mips_mc_ctrl_ext.sv
// Multicycle MIPS control FSM with memory wait handshake, PC enable logic and retired-instruction counter.
// Define MIPS_MC_CTRL_DFT_EN to expose the state register on DFT_state (tied to 0 otherwise).
module mips_mc_ctrl_ext #(
  parameter int BIT_SEL   = 3,
  parameter int CNT_WIDTH = 16,
  parameter int STATE_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           Op,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 ImmZext,
  output logic [1:0]           PCSrc,
  output logic [BIT_SEL:0]     ALUControl,
  output logic                 PCEn,
  output logic                 illegal_op,
  output logic [CNT_WIDTH-1:0] retired,
  output logic [STATE_W-1:0]   DFT_state
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMRD    = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWR    = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_RTYPE_EX = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_SHIFT_EX = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ALU_WB   = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_IMM_EX   = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_IMM_WB   = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_JUMP     = STATE_W'(12);

  localparam int AW = BIT_SEL + 1;
  localparam logic [BIT_SEL:0] ALU_AND = AW'(4'b0000);
  localparam logic [BIT_SEL:0] ALU_OR  = AW'(4'b0001);
  localparam logic [BIT_SEL:0] ALU_ADD = AW'(4'b0010);
  localparam logic [BIT_SEL:0] ALU_SUB = AW'(4'b0110);
  localparam logic [BIT_SEL:0] ALU_SLT = AW'(4'b0111);
  localparam logic [BIT_SEL:0] ALU_SLL = AW'(4'b1000);
  localparam logic [BIT_SEL:0] ALU_SRL = AW'(4'b1001);
  localparam logic [BIT_SEL:0] ALU_NOR = AW'(4'b1100);

  logic [STATE_W-1:0] state, next_state;
  logic [STATE_W-1:0] dec_next;
  logic [BIT_SEL:0]   dec_alu, ex_alu;
  logic               dec_zext, dec_ok;
  logic               is_sw, is_bne, ex_zext;
  logic               retire;

  // Opcode/funct decode, only consumed while in DECODE.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    dec_next = S_FETCH;
    dec_alu  = ALU_ADD;
    dec_zext = 1'b0;
    dec_ok   = 1'b1;
    unique case (Op)
      6'b100011, 6'b101011: dec_next = S_MEMADR;
      6'b000000: begin
        dec_next = S_RTYPE_EX;
        case (Funct)
          6'b100000: dec_alu = ALU_ADD;
          6'b100010: dec_alu = ALU_SUB;
          6'b100100: dec_alu = ALU_AND;
          6'b100101: dec_alu = ALU_OR;
          6'b100111: dec_alu = ALU_NOR;
          6'b101010: dec_alu = ALU_SLT;
          6'b000000: begin dec_alu = ALU_SLL; dec_next = S_SHIFT_EX; end
          6'b000010: begin dec_alu = ALU_SRL; dec_next = S_SHIFT_EX; end
          default:   begin dec_ok = 1'b0; dec_next = S_FETCH; end
        endcase
      end
      6'b000100, 6'b000101: dec_next = S_BRANCH;
      6'b001000: dec_next = S_IMM_EX;
      6'b001100: begin dec_next = S_IMM_EX; dec_alu = ALU_AND; dec_zext = 1'b1; end
      6'b001101: begin dec_next = S_IMM_EX; dec_alu = ALU_OR;  dec_zext = 1'b1; end
      6'b000010: dec_next = S_JUMP;
      default:   dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   next_state = dec_next;
      S_MEMADR:   next_state = is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:    next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:    next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: next_state = S_ALU_WB;
      S_SHIFT_EX: next_state = S_ALU_WB;
      S_IMM_EX:   next_state = S_IMM_WB;
      default:    next_state = S_FETCH;
    endcase
  end

  assign retire = (state == S_MEMWB) || (state == S_ALU_WB) || (state == S_IMM_WB) ||
                  (state == S_BRANCH) || (state == S_JUMP) || ((state == S_MEMWR) && mem_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FETCH;
      retired <= '0;
      is_sw   <= 1'b0;
      is_bne  <= 1'b0;
      ex_alu  <= ALU_AND;
      ex_zext <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state <= next_state;
      if (retire) retired <= retired + 1'b1;
      // Latch the op class so execute states ignore later IR/bus changes.
      if (state == S_DECODE) begin
        is_sw   <= (Op == 6'b101011);
        is_bne  <= (Op == 6'b000101);
        ex_alu  <= dec_alu;
        ex_zext <= dec_zext;
      end
    end
  end

  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmZext    = 1'b0;
    PCSrc      = 2'b00;
    ALUControl = ALU_AND;
    PCEn       = 1'b0;
    case (state)
      S_FETCH:    begin ALUSrcB = 2'b01; ALUControl = ALU_ADD; IRWrite = mem_ready; PCEn = mem_ready; end
      S_DECODE:   begin ALUSrcB = 2'b11; ALUControl = ALU_ADD; end
      S_MEMADR:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; ALUControl = ALU_ADD; end
      S_MEMRD:    IorD = 1'b1;
      S_MEMWB:    begin MemtoReg = 1'b1; RegWrite = 1'b1; end
      S_MEMWR:    begin IorD = 1'b1; MemWrite = mem_ready; end
      S_RTYPE_EX: begin ALUSrcA = 2'b01; ALUControl = ex_alu; end
      S_SHIFT_EX: begin ALUSrcA = 2'b10; ALUControl = ex_alu; end
      S_ALU_WB:   begin RegDst = 1'b1; RegWrite = 1'b1; end
      S_IMM_EX:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; ALUControl = ex_alu; ImmZext = ex_zext; end
      S_IMM_WB:   RegWrite = 1'b1;
      S_BRANCH:   begin ALUSrcA = 2'b01; ALUControl = ALU_SUB; PCSrc = 2'b01; PCEn = is_bne ? ~Zero : Zero; end
      S_JUMP:     begin PCSrc = 2'b10; PCEn = 1'b1; end
      default:    ;
    endcase
    // Strobes are blocked combinationally while reset is held, even within the reset cycle.
    if (!rst) begin
      IRWrite  = 1'b0;
      PCEn     = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign illegal_op = (state == S_DECODE) && !dec_ok;

`ifdef MIPS_MC_CTRL_DFT_EN
  assign DFT_state = state;
`else
  assign DFT_state = '0;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl_ext.sv
// Scoreboard bench for mips_mc_ctrl_ext: per-cycle expected control vectors from an instruction-level model.
module tb_mips_mc_ctrl_ext;
  localparam int CW = 4;

`ifdef MIPS_MC_CTRL_DFT_EN
  localparam bit DFT_EN = 1'b1;
`else
  localparam bit DFT_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] op = '0, fn = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic iord, memwrite, irwrite, regwrite, regdst, memtoreg, immzext, pcen, illegal;
  logic [1:0] srca, srcb, pcsrc;
  logic [3:0] aluctl, dft;
  logic [CW-1:0] retired;

  mips_mc_ctrl_ext #(.BIT_SEL(3), .CNT_WIDTH(CW), .STATE_W(4)) dut (
    .clk(clk), .rst(rst_n), .Op(op), .Funct(fn), .Zero(zero), .mem_ready(mem_ready),
    .IorD(iord), .MemWrite(memwrite), .IRWrite(irwrite), .RegWrite(regwrite),
    .RegDst(regdst), .MemtoReg(memtoreg), .ALUSrcA(srca), .ALUSrcB(srcb),
    .ImmZext(immzext), .PCSrc(pcsrc), .ALUControl(aluctl), .PCEn(pcen),
    .illegal_op(illegal), .retired(retired), .DFT_state(dft)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic iord, memwrite, irwrite, regwrite, regdst, memtoreg;
    logic [1:0] srca, srcb;
    logic immzext;
    logic [1:0] pcsrc;
    logic [3:0] aluctl;
    logic pcen, illegal;
    logic [CW-1:0] retired;
    logic [3:0] dft;
  } vec_t;

  typedef enum {C_LW, C_SW, C_RT, C_SH, C_IMM, C_BR, C_J, C_ILL} cls_t;

  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110;

  vec_t  sb[$];
  string tags[$];
  int    n_vec = 0, n_bad = 0;
  int    cnt = 0;
  logic [5:0] legal_ops[9] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h02};
  logic [5:0] legal_fn[8]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02};

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic vec_t blank(input int st);
    vec_t e = '0;
    e.retired = CW'(cnt);
    e.dft = DFT_EN ? 4'(st) : 4'd0;
    return e;
  endfunction

  // Instruction-level reference: class, execute ALU op and immediate extension.
  task automatic classify(input logic [5:0] o, input logic [5:0] f,
                          output cls_t c, output logic [3:0] alu, output logic zx);
    c = C_ILL; alu = ADD; zx = 1'b0;
    case (o)
      6'h23: c = C_LW;
      6'h2B: c = C_SW;
      6'h04, 6'h05: c = C_BR;
      6'h02: c = C_J;
      6'h08: c = C_IMM;
      6'h0C: begin c = C_IMM; alu = 4'b0000; zx = 1'b1; end
      6'h0D: begin c = C_IMM; alu = 4'b0001; zx = 1'b1; end
      6'h00: begin
        case (f)
          6'h20: begin c = C_RT; alu = 4'b0010; end
          6'h22: begin c = C_RT; alu = 4'b0110; end
          6'h24: begin c = C_RT; alu = 4'b0000; end
          6'h25: begin c = C_RT; alu = 4'b0001; end
          6'h27: begin c = C_RT; alu = 4'b1100; end
          6'h2A: begin c = C_RT; alu = 4'b0111; end
          6'h00: begin c = C_SH; alu = 4'b1000; end
          6'h02: begin c = C_SH; alu = 4'b1001; end
          default: c = C_ILL;
        endcase
      end
      default: c = C_ILL;
    endcase
  endtask

  task automatic step(input vec_t e, input string tag, input logic r, input logic mr,
                      input logic z, input logic [5:0] o, input logic [5:0] f);
    @(posedge clk); #1;
    rst_n = r; mem_ready = mr; zero = z; op = o; fn = f;
    sb.push_back(e);
    tags.push_back(tag);
  endtask

  task automatic fetch(input int stalls);
    vec_t e;
    for (int i = 0; i < stalls; i++) begin
      e = blank(0); e.srcb = 2'b01; e.aluctl = ADD;
      step(e, "fetch_wait", 1'b1, 1'b0, rb(), r6(), r6());
    end
    e = blank(0); e.srcb = 2'b01; e.aluctl = ADD; e.irwrite = 1'b1; e.pcen = 1'b1;
    step(e, "fetch", 1'b1, 1'b1, rb(), r6(), r6());
  endtask

  // zf < 0 picks a random Zero in the branch cycle. Op/Funct are garbage outside DECODE.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int sf, input int sm, input int zf);
    cls_t c; logic [3:0] alu; logic zx, z; vec_t e; int ms;
    classify(o, f, c, alu, zx);
    fetch(sf);
    e = blank(1); e.srcb = 2'b11; e.aluctl = ADD; e.illegal = (c == C_ILL);
    step(e, "decode", 1'b1, rb(), rb(), o, f);
    case (c)
      C_LW, C_SW: begin
        ms = (c == C_LW) ? 3 : 5;
        e = blank(2); e.srca = 2'b01; e.srcb = 2'b10; e.aluctl = ADD;
        step(e, "memadr", 1'b1, rb(), rb(), r6(), r6());
        for (int i = 0; i < sm; i++) begin
          e = blank(ms); e.iord = 1'b1;
          step(e, "mem_wait", 1'b1, 1'b0, rb(), r6(), r6());
        end
        e = blank(ms); e.iord = 1'b1; e.memwrite = (c == C_SW);
        step(e, "mem_done", 1'b1, 1'b1, rb(), r6(), r6());
        if (c == C_LW) begin
          e = blank(4); e.memtoreg = 1'b1; e.regwrite = 1'b1;
          step(e, "memwb", 1'b1, rb(), rb(), r6(), r6());
        end
      end
      C_RT, C_SH: begin
        e = blank(c == C_RT ? 6 : 7); e.srca = (c == C_RT) ? 2'b01 : 2'b10; e.aluctl = alu;
        step(e, "alu_ex", 1'b1, rb(), rb(), r6(), r6());
        e = blank(8); e.regdst = 1'b1; e.regwrite = 1'b1;
        step(e, "alu_wb", 1'b1, rb(), rb(), r6(), r6());
      end
      C_IMM: begin
        e = blank(9); e.srca = 2'b01; e.srcb = 2'b10; e.aluctl = alu; e.immzext = zx;
        step(e, "imm_ex", 1'b1, rb(), rb(), r6(), r6());
        e = blank(10); e.regwrite = 1'b1;
        step(e, "imm_wb", 1'b1, rb(), rb(), r6(), r6());
      end
      C_BR: begin
        z = (zf < 0) ? rb() : logic'(zf);
        e = blank(11); e.srca = 2'b01; e.aluctl = SUB; e.pcsrc = 2'b01;
        e.pcen = (o == 6'h05) ? !z : z;
        step(e, "branch", 1'b1, rb(), z, r6(), r6());
      end
      C_J: begin
        e = blank(12); e.pcsrc = 2'b10; e.pcen = 1'b1;
        step(e, "jump", 1'b1, rb(), rb(), r6(), r6());
      end
      default: ;
    endcase
    if (c != C_ILL) cnt = (cnt + 1) % (1 << CW);
  endtask

  task automatic reset_cycles(input int n, input string tag);
    vec_t e;
    for (int i = 0; i < n; i++) begin
      e = blank(0); e.srcb = 2'b01; e.aluctl = ADD;
      step(e, tag, 1'b0, 1'b1, rb(), r6(), r6());
    end
  endtask

  initial begin : monitor
    vec_t e, a;
    string t;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        t = tags.pop_front();
        a = {iord, memwrite, irwrite, regwrite, regdst, memtoreg, srca, srcb,
             immzext, pcsrc, aluctl, pcen, illegal, retired, dft};
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s @%0t: got %h want %h", t, $time, a, e);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [5:0] o, f;
    vec_t e;
    reset_cycles(3, "reset");
    run_instr(6'h23, r6(), 0, 0, -1);          // lw right after reset release
    run_instr(6'h2B, r6(), 3, 0, -1);          // fetch waits 3 cycles
    run_instr(6'h05, r6(), 0, 0, 0);           // bne taken
    run_instr(6'h05, r6(), 0, 0, 1);           // bne not taken
    run_instr(6'h04, r6(), 0, 0, 1);           // beq taken
    run_instr(6'h04, r6(), 0, 0, 0);           // beq not taken
    run_instr(6'h00, 6'h02, 0, 0, -1);         // srl
    run_instr(6'h3F, r6(), 0, 0, -1);          // illegal opcode
    run_instr(6'h00, 6'h3F, 1, 0, -1);         // illegal funct
    run_instr(6'h23, r6(), 0, 2, -1);          // lw with memory wait
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        o = (rb() == 1'b1) ? r6() : 6'h00;
        f = r6();
      end else begin
        o = legal_ops[$urandom_range(0, 8)];
        f = (o == 6'h00) ? legal_fn[$urandom_range(0, 7)] : r6();
      end
      run_instr(o, f, $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end
    if (cnt == 0) run_instr(6'h02, r6(), 0, 0, -1);
    // sw stalled in MEMWR, then reset falls with mem_ready high.
    fetch(0);
    e = blank(1); e.srcb = 2'b11; e.aluctl = ADD;
    step(e, "decode_sw", 1'b1, 1'b1, 1'b0, 6'h2B, r6());
    e = blank(2); e.srca = 2'b01; e.srcb = 2'b10; e.aluctl = ADD;
    step(e, "memadr_sw", 1'b1, 1'b1, 1'b0, r6(), r6());
    e = blank(5); e.iord = 1'b1;
    step(e, "memwr_wait", 1'b1, 1'b0, 1'b0, r6(), r6());
    cnt = 0;
    reset_cycles(1, "mid_reset");
    reset_cycles(2, "reset_hold");
    run_instr(6'h08, r6(), 0, 0, -1);
    run_instr(6'h02, r6(), 1, 0, -1);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
